// File: rtl/mod_addsub_serial.sv
// Limb-serial modular add/subtract: result = (a+b) mod p or (a-b) mod p, one LIMB per cycle.
// Latency NLIMB cycles (2*NLIMB for borrowing subtract); result held in DONE until out_ready.
module mod_addsub_serial #(
  parameter int WIDTH = 256,
  parameter int LIMB  = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  localparam int NLIMB = WIDTH / LIMB;
  localparam int CW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NLIMB - 1);

  typedef enum logic [1:0] {IDLE, CALC, CORR, DONE} state_t;

  state_t           state, state_nxt;
  logic             op_r;
  logic [WIDTH-1:0] a_r, b_r, p_r, s_r, t_r, res_r;
  logic [CW-1:0]    cnt;
  logic             cy;   // carry/borrow of s (CALC), carry of s+p (CORR)
  logic             bw;   // borrow of t = s-p
  logic             accept, last;

  logic [LIMB:0]    s_limb, t_limb, c_limb;
  logic [WIDTH-1:0] s_next, t_next, corr_next, p_rot;

  // Operands shift right so the active limb always sits in bits [LIMB-1:0];
  // p rotates so it is back in place for CORR after NLIMB steps.
  always_comb begin
    if (op_r)
      s_limb = {1'b0, a_r[LIMB-1:0]} - {1'b0, b_r[LIMB-1:0]} - {{LIMB{1'b0}}, cy};
    else
      s_limb = {1'b0, a_r[LIMB-1:0]} + {1'b0, b_r[LIMB-1:0]} + {{LIMB{1'b0}}, cy};
    t_limb = {1'b0, s_limb[LIMB-1:0]} - {1'b0, p_r[LIMB-1:0]} - {{LIMB{1'b0}}, bw};
    c_limb = {1'b0, s_r[LIMB-1:0]} + {1'b0, p_r[LIMB-1:0]} + {{LIMB{1'b0}}, cy};

    s_next = s_r >> LIMB;
    s_next[WIDTH-1 -: LIMB] = s_limb[LIMB-1:0];
    t_next = t_r >> LIMB;
    t_next[WIDTH-1 -: LIMB] = t_limb[LIMB-1:0];
    corr_next = s_r >> LIMB;
    corr_next[WIDTH-1 -: LIMB] = c_limb[LIMB-1:0];
    p_rot = (p_r >> LIMB) | (p_r << (WIDTH - LIMB));
  end

  assign last = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    out_valid = (state == DONE);
    in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    accept    = in_valid && in_ready;
    case (state)
      IDLE: if (accept) state_nxt = CALC;
      CALC: begin
        if (last) begin
          if (op_r && s_limb[LIMB]) state_nxt = CORR;
          else                      state_nxt = DONE;
        end
      end
      CORR: if (last) state_nxt = DONE;
      DONE: begin
        if (out_ready) state_nxt = accept ? CALC : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r  <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      p_r   <= '0;
      s_r   <= '0;
      t_r   <= '0;
      res_r <= '0;
      cnt   <= '0;
      cy    <= 1'b0;
      bw    <= 1'b0;
    end else if (accept) begin
      op_r <= op;
      a_r  <= a;
      b_r  <= b;
      p_r  <= p;
      cnt  <= '0;
      cy   <= 1'b0;
      bw   <= 1'b0;
    end else begin
      case (state)
        CALC: begin
          a_r <= a_r >> LIMB;
          b_r <= b_r >> LIMB;
          p_r <= p_rot;
          s_r <= s_next;
          t_r <= t_next;
          bw  <= t_limb[LIMB];
          cy  <= last ? 1'b0 : s_limb[LIMB];
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) begin
            // Add: s overflowed, or s >= p, means the reduced value t is the answer.
            if (!op_r)
              res_r <= (s_limb[LIMB] || !t_limb[LIMB]) ? t_next : s_next;
            else if (!s_limb[LIMB])
              res_r <= s_next;
          end
        end
        CORR: begin
          p_r <= p_rot;
          s_r <= corr_next;
          cy  <= last ? 1'b0 : c_limb[LIMB];
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) res_r <= corr_next;
        end
        default: ;
      endcase
    end
  end

  assign result = res_r;

endmodule
